// File: rtl/clock_en_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Package : clk_ctrl_pkg
// Shared state encoding and constants for clock_en_ctrl.  Rev 1.0
// ------------------------------------------------------------------
package clk_ctrl_pkg;

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} clk_state_t;

  localparam int SYNC_STAGES = 2;

  localparam logic [0:0] c_ST_PAUSE = 1'(PAUSE);
  localparam logic [0:0] c_ST_RUN   = 1'(RUN);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_en_ctrl_btn_sync_edge.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : btn_sync_edge
// Button synchronizer, rising-edge pulse and tick-based auto-repeat. Rev 1.0
// ------------------------------------------------------------------
module btn_sync_edge
  import clk_ctrl_pkg::*;
#(
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  input  logic enable,
  output logic pulse,
  output logic held
);

  localparam int c_CNT_W = $clog2(max_int(REPEAT_DLY, REPEAT_RATE) + 1);
  localparam logic [c_CNT_W-1:0] c_DLY_LAST  = c_CNT_W'(REPEAT_DLY - 1);
  localparam logic [c_CNT_W-1:0] c_RATE_LAST = c_CNT_W'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_armed;
  logic                   r_rep_mode;
  logic [c_CNT_W-1:0]     r_cnt;
  logic                   r_pulse;

  logic w_level;
  logic w_rise;
  logic w_active;
  logic w_rep_hit;

  assign w_level  = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_level & ~r_prev;
  // Only a press that began while enabled may auto-repeat.
  assign w_active = enable & w_level & r_armed;
  assign w_rep_hit = w_active & tick &
                     (r_rep_mode ? (r_cnt == c_RATE_LAST) : (r_cnt == c_DLY_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_armed    <= 1'b0;
      r_rep_mode <= 1'b0;
      r_cnt      <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], btn};
      r_prev  <= w_level;
      r_pulse <= (enable & w_rise) | w_rep_hit;
      if (!enable || !w_level) begin
        r_armed    <= 1'b0;
        r_rep_mode <= 1'b0;
        r_cnt      <= '0;
      end else if (w_rise) begin
        r_armed    <= 1'b1;
        r_rep_mode <= 1'b0;
        r_cnt      <= '0;
      end else if (r_armed && tick) begin
        if (w_rep_hit) begin
          r_rep_mode <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign pulse = r_pulse;
  assign held  = w_level;

endmodule
`default_nettype wire

// File: rtl/clock_en_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : clock_en_ctrl
// Tick prescaler, RUN/PAUSE FSM and enable muxing for time counters. Rev 1.0
// ------------------------------------------------------------------
module clock_en_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 100,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic set_min_btn,
  input  logic set_hr_btn,
  input  logic sec_z,
  input  logic min_z,
  output logic tick,
  output logic sec_en,
  output logic min_en,
  output logic hr_en,
  output logic running
);

  localparam int c_PW = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(TICK_DIV - 1);

  logic [c_PW-1:0]        r_presc;
  logic                   r_tick;
  logic [SYNC_STAGES-1:0] r_run_sync;
  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic                   r_both_lock;

  logic w_run_s;
  logic w_pause;
  logic w_enter_run;
  logic w_both;
  logic w_btn_en;
  logic w_min_pulse;
  logic w_hr_pulse;
  logic w_min_held;
  logic w_hr_held;

  assign w_run_s     = r_run_sync[SYNC_STAGES-1];
  assign w_pause     = (r_state == c_ST_PAUSE);
  assign w_enter_run = w_pause & w_run_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_sync <= '0;
    end else begin
      r_run_sync <= {r_run_sync[SYNC_STAGES-2:0], run};
    end
  end

  // Restart the prescaler on entering RUN so the first second is full length.
  always_ff @(posedge clk) begin
    if (rst || w_enter_run) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= (r_presc == c_PRE_LAST);
      r_presc <= (r_presc == c_PRE_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_PAUSE: if (w_run_s)  w_state_nxt = c_ST_RUN;
      c_ST_RUN:   if (!w_run_s) w_state_nxt = c_ST_PAUSE;
      default:    w_state_nxt = c_ST_PAUSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_PAUSE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Once both buttons are seen together, stay locked until both are released.
  assign w_both = w_min_held & w_hr_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_both_lock <= 1'b0;
    end else if (w_both) begin
      r_both_lock <= 1'b1;
    end else if (!w_min_held && !w_hr_held) begin
      r_both_lock <= 1'b0;
    end
  end

  assign w_btn_en = w_pause & ~w_both & ~r_both_lock;

  btn_sync_edge #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_min_btn (
    .clk    (clk),
    .rst    (rst),
    .btn    (set_min_btn),
    .tick   (r_tick),
    .enable (w_btn_en),
    .pulse  (w_min_pulse),
    .held   (w_min_held)
  );

  btn_sync_edge #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_hr_btn (
    .clk    (clk),
    .rst    (rst),
    .btn    (set_hr_btn),
    .tick   (r_tick),
    .enable (w_btn_en),
    .pulse  (w_hr_pulse),
    .held   (w_hr_held)
  );

  assign tick    = r_tick;
  assign running = ~w_pause;
  assign sec_en  = ~w_pause & r_tick;
  assign min_en  = w_pause ? w_min_pulse : (r_tick & sec_z);
  assign hr_en   = w_pause ? w_hr_pulse  : (r_tick & sec_z & min_z);

endmodule
`default_nettype wire

// File: tb/tb_clock_en_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : tb_clock_en_ctrl
// Directed bench for clock_en_ctrl driving real mod-60/60/24 counters. Rev 1.0
// ------------------------------------------------------------------
module tb_clock_en_ctrl;

  logic clk = 1'b0;
  logic rst, run, set_min_btn, set_hr_btn;
  logic sec_z, min_z;
  logic tick, sec_en, min_en, hr_en, running;

  logic [5:0] sec, min, ld_sec, ld_min;
  logic [4:0] hr, ld_hr;
  logic       ld;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hits   = 0;

  always #5 clk = ~clk;

  clock_en_ctrl #(
    .TICK_DIV    (4),
    .REPEAT_DLY  (3),
    .REPEAT_RATE (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .set_min_btn (set_min_btn),
    .set_hr_btn  (set_hr_btn),
    .sec_z       (sec_z),
    .min_z       (min_z),
    .tick        (tick),
    .sec_en      (sec_en),
    .min_en      (min_en),
    .hr_en       (hr_en),
    .running     (running)
  );

  // Load model: the three cascaded time counters.
  always @(posedge clk) begin
    if (rst) begin
      sec <= '0; min <= '0; hr <= '0;
    end else if (ld) begin
      sec <= ld_sec; min <= ld_min; hr <= ld_hr;
    end else begin
      if (sec_en) sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
      if (min_en) min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
      if (hr_en)  hr  <= (hr  == 5'd23) ? 5'd0 : hr + 5'd1;
    end
  end

  assign sec_z = (sec == 6'd59);
  assign min_z = (min == 6'd59);

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; set_min_btn = 1'b0; set_hr_btn = 1'b0;
    ld = 1'b0; ld_sec = '0; ld_min = '0; ld_hr = '0;

    // Reset state and PAUSE ticking
    step(5);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_sec_en", 32'(sec_en), 0);
    chk("rst_min_en", 32'(min_en), 0);
    chk("rst_hr_en", 32'(hr_en), 0);
    chk("rst_running", 32'(running), 0);
    rst = 1'b0; cyc = 0;
    step(3); chk("pause_tick_c3", 32'(tick), 0);
    step(1); chk("pause_tick_c4", 32'(tick), 1);
    chk("pause_sec_en_c4", 32'(sec_en), 0);
    step(1); chk("pause_tick_c5", 32'(tick), 0);
    step(3); chk("pause_tick_c8", 32'(tick), 1);
    chk("pause_sec_static", 32'(sec), 0);

    // RUN from reset
    rst = 1'b1; step(2);
    rst = 1'b0; run = 1'b1; cyc = 0;
    step(2); chk("run_running_c2", 32'(running), 0);
    step(1); chk("run_running_c3", 32'(running), 1);
    step(3); chk("run_sec_en_c6", 32'(sec_en), 0);
    step(1); chk("run_sec_en_c7", 32'(sec_en), 1);
    step(1); chk("run_sec_en_c8", 32'(sec_en), 0);
    chk("run_sec_c8", 32'(sec), 1);
    step(231); chk("run_sec_en_c239", 32'(sec_en), 1);
    chk("run_min_en_c239", 32'(min_en), 0);
    chk("run_sec_c239", 32'(sec), 58);
    step(1); chk("run_sec_c240", 32'(sec), 59);
    chk("run_sec_en_c240", 32'(sec_en), 0);
    step(3); chk("run_sec_en_c243", 32'(sec_en), 1);
    chk("run_min_en_c243", 32'(min_en), 1);
    chk("run_hr_en_c243", 32'(hr_en), 0);
    step(1); chk("run_sec_wrap", 32'(sec), 0);
    chk("run_min_c244", 32'(min), 1);

    // Full carry 23:59:59 -> 00:00:00
    ld = 1'b1; ld_sec = 6'd59; ld_min = 6'd59; ld_hr = 5'd23;
    step(1); ld = 1'b0;
    step(2); chk("carry_sec_en", 32'(sec_en), 1);
    chk("carry_min_en", 32'(min_en), 1);
    chk("carry_hr_en", 32'(hr_en), 1);
    step(1); chk("carry_sec", 32'(sec), 0);
    chk("carry_min", 32'(min), 0);
    chk("carry_hr", 32'(hr), 0);
    chk("carry_sec_en_off", 32'(sec_en), 0);

    // PAUSE and single set_min press
    run = 1'b0;
    step(2); chk("pause_running_c250", 32'(running), 1);
    step(1); chk("pause_running_c251", 32'(running), 0);
    chk("pause_tick_c251", 32'(tick), 1);
    chk("pause_sec_en_c251", 32'(sec_en), 0);
    set_min_btn = 1'b1;
    step(1); set_min_btn = 1'b0;
    step(1); chk("setmin_early", 32'(min_en), 0);
    step(1); chk("setmin_pulse", 32'(min_en), 1);
    chk("setmin_hr_en", 32'(hr_en), 0);
    chk("setmin_sec_en", 32'(sec_en), 0);
    step(1); chk("setmin_single", 32'(min_en), 0);
    chk("setmin_min", 32'(min), 1);

    // Hold set_hr_btn: pulse at 259, repeats at 268+8k up to 332
    ld = 1'b1; ld_sec = 6'd0; ld_min = 6'd1; ld_hr = 5'd22;
    step(1); ld = 1'b0; set_hr_btn = 1'b1; hits = 0;
    while (cyc < 345) begin
      step(1);
      if (cyc == 336) set_hr_btn = 1'b0;
      chk("hold_hr_en", 32'(hr_en),
          32'((cyc == 259) || (cyc >= 268 && cyc <= 332 && ((cyc - 268) % 8 == 0))));
      chk("hold_tick", 32'(tick), 32'(((cyc - 3) % 4) == 0));
      if (cyc == 269) chk("hold_hr_wrap", 32'(hr), 0);
      if (min_en || sec_en) hits++;
    end
    chk("hold_stray_en", 32'(hits), 0);
    chk("hold_hr_final", 32'(hr), 8);
    chk("hold_min_final", 32'(min), 1);

    // Both buttons: locked until both released
    step(1); set_min_btn = 1'b1; set_hr_btn = 1'b1; hits = 0;
    while (cyc < 386) begin step(1); if (min_en || hr_en) hits++; end
    set_hr_btn = 1'b0;
    while (cyc < 406) begin step(1); if (min_en || hr_en) hits++; end
    set_min_btn = 1'b0;
    step(4); set_min_btn = 1'b1;
    step(2); if (min_en || hr_en) hits++;
    chk("both_no_pulses", 32'(hits), 0);
    chk("both_hr_static", 32'(hr), 8);
    step(1); chk("both_repress_pulse", 32'(min_en), 1);
    chk("both_repress_hr_en", 32'(hr_en), 0);

    // Reset mid-repeat: third tick at 423 would give a pulse at 424
    hits = 0;
    while (cyc < 423) begin step(1); if (min_en) hits++; end
    chk("rep_no_early", 32'(hits), 0);
    rst = 1'b1;
    step(1); chk("midrst_min_en", 32'(min_en), 0);
    chk("midrst_tick", 32'(tick), 0);
    chk("midrst_hr_en", 32'(hr_en), 0);
    chk("midrst_running", 32'(running), 0);
    step(1); set_min_btn = 1'b0;
    chk("midrst_min_en2", 32'(min_en), 0);
    step(2); rst = 1'b0; cyc = 0;

    // PAUSE->RUN mid-prescaler: tick due at 8 is suppressed
    step(4); chk("rerun_tick_c4", 32'(tick), 1);
    step(1); run = 1'b1;
    step(3); chk("rerun_running_c8", 32'(running), 1);
    chk("rerun_tick_c8", 32'(tick), 0);
    chk("rerun_sec_en_c8", 32'(sec_en), 0);
    step(3); chk("rerun_sec_en_c11", 32'(sec_en), 0);
    step(1); chk("rerun_sec_en_c12", 32'(sec_en), 1);

    // Press during RUN, then back to PAUSE while held: discarded
    set_min_btn = 1'b1; run = 1'b0; hits = 0;
    while (cyc < 40) begin
      step(1);
      if (cyc == 14) chk("toggle_running_c14", 32'(running), 1);
      if (cyc == 15) chk("toggle_running_c15", 32'(running), 0);
      if (min_en || hr_en) hits++;
    end
    chk("toggle_discarded", 32'(hits), 0);
    set_min_btn = 1'b0;
    step(4); set_min_btn = 1'b1;
    step(2); chk("fresh_early", 32'(min_en), 0);
    step(1); chk("fresh_pulse", 32'(min_en), 1);
    step(1); chk("fresh_single", 32'(min_en), 0);
    set_min_btn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
